// File: rtl/aes_inv_rcon.sv
// Reverse-order AES round-constant generator for the decryption key schedule.
// A key load (kld) starts the sequence at START_IDX. Each adv cycle then steps
// one round constant backward, down to 0x01, where the index saturates.
// All outputs are registered. There is no combinational path from inputs to outputs.
module aes_inv_rcon #(
  // rcon index loaded on kld: 9 for AES-128, 7 for AES-192, 6 for AES-256.
  parameter int unsigned START_IDX = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kld,
  input  logic        adv,
  output logic [31:0] out,
  output logic [3:0]  rnd,
  output logic        valid,
  output logic        last
);

  // The state is carried by r_valid. It is not a separate register.
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [3:0] START_RND = 4'(START_IDX);

  // Fixed index-to-byte map. Indices 10..15 are unreachable and read as zero.
  function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = 8'h01;
      4'd1:    b = 8'h02;
      4'd2:    b = 8'h04;
      4'd3:    b = 8'h08;
      4'd4:    b = 8'h10;
      4'd5:    b = 8'h20;
      4'd6:    b = 8'h40;
      4'd7:    b = 8'h80;
      4'd8:    b = 8'h1b;
      4'd9:    b = 8'h36;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic [31:0] r_out;
  logic [3:0]  r_rnd;
  logic        r_valid;
  logic        r_last;

  logic        w_state;
  logic        w_step;
  logic [3:0]  w_rnd_dec;
  logic [31:0] w_out_nxt;
  logic [3:0]  w_rnd_nxt;
  logic        w_valid_nxt;
  logic        w_last_nxt;

  assign w_state   = r_valid;
  assign w_rnd_dec = r_rnd - 4'd1;
  // A step happens only in RUN with a non-zero index. At index 0 the sequence saturates and does not wrap.
  assign w_step    = (w_state == ST_RUN) && adv && (r_rnd != 4'd0);

  // Next-state selection. kld has priority over adv. With neither active, every output holds.
  always_comb begin
    w_out_nxt   = r_out;
    w_rnd_nxt   = r_rnd;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    if (kld) begin
      w_rnd_nxt   = START_RND;
      w_out_nxt   = {rcon_byte(START_RND), 24'h000000};
      w_valid_nxt = 1'b1;
      w_last_nxt  = (START_RND == 4'd0);
    end else if (w_step) begin
      // out comes from the next index, so it changes on the same edge as rnd and last.
      w_rnd_nxt   = w_rnd_dec;
      w_out_nxt   = {rcon_byte(w_rnd_dec), 24'h000000};
      w_last_nxt  = (w_rnd_dec == 4'd0);
    end
  end

  // Output registers. An asynchronous reset returns the block to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= 32'h0000_0000;
      r_rnd   <= 4'd0;
      r_valid <= ST_IDLE;
      r_last  <= 1'b0;
    end else begin
      r_out   <= w_out_nxt;
      r_rnd   <= w_rnd_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign out   = r_out;
  assign rnd   = r_rnd;
  assign valid = r_valid;
  assign last  = r_last;

  // Invariants that hold by construction.
  a_last_consistent : assert property (@(posedge clk) disable iff (rst)
    last == (valid && (rnd == 4'd0)));
  a_rnd_bounded : assert property (@(posedge clk) disable iff (rst)
    rnd <= START_RND);
  a_out_matches_rnd : assert property (@(posedge clk) disable iff (rst)
    valid |-> (out == {rcon_byte(rnd), 24'h000000}));
  a_idle_quiet : assert property (@(posedge clk) disable iff (rst)
    !valid |-> (out == 32'h0 && rnd == 4'd0 && !last));

endmodule

// File: doc/aes_inv_rcon.md
# aes_inv_rcon

Reverse-order AES round-constant generator for the decryption key schedule. It is the counterpart of `aes_rcon`: that block steps 0x01, 0x02, … 0x36 forward from a key load, while this block starts at the last round constant and steps backward to 0x01. It sits beside the inverse key expansion and is driven by the same `kld` strobe plus an explicit advance enable. Its registered outputs provide the rcon word, the current round index and end-of-sequence flags.

## Interface
- `START_IDX`, default 9, is the rcon index loaded on `kld`. The legal range is 0..9: 9 for AES-128, 7 for AES-192, 6 for AES-256.
- `clk`  in  1  is the single clock. All state updates on its rising edge.
- `rst`  in  1  is an asynchronous, active-high reset.
- `kld`  in  1  is the key-load strobe. It restarts the sequence at `START_IDX`.
- `adv`  in  1  is the advance enable. It steps one constant backward per cycle while high.
- `out`  out  32  is the current round constant word, `{rcon_byte, 24'h000000}`.
- `rnd`  out  4  is the current rcon index, 0..9.
- `valid`  out  1  is high once a sequence has been loaded.
- `last`  out  1  is high while `valid` is set and `rnd == 0` (`out` = 0x01000000).

## Operation
- Index-to-byte map, fixed:
  - 0:0x01, 1:0x02, 2:0x04, 3:0x08, 4:0x10
  - 5:0x20, 6:0x40, 7:0x80, 8:0x1b, 9:0x36
  - Indices 10..15 map to 0x00 and are unreachable in normal operation.
- All four outputs are registers. `out` is registered from the next-index lookup, not decoded from `rnd`.
- Reset (async, any time): `out`=32'h0, `rnd`=0, `valid`=0, `last`=0.
- Two states, derived from `valid`:
  - IDLE (`valid`=0): `adv` is ignored and outputs hold their reset values.
  - RUN (`valid`=1): the backward sequence is active.
- `kld`=1 in any state:
  - next `rnd`=`START_IDX`, `out`=map(`START_IDX`)<<24, `valid`=1.
  - `last`=(`START_IDX`==0).
- RUN, `kld`=0, `adv`=1, `rnd`>0:
  - `rnd` decrements by 1 and `out`=map(`rnd`-1)<<24.
  - `last` rises in the cycle `rnd` becomes 0.
- RUN, `kld`=0, `adv`=1, `rnd`==0: the index saturates. All outputs hold; there is no wrap to 9.
- RUN, `kld`=0, `adv`=0: all outputs hold.
- Simultaneous `kld` and `adv`: `kld` wins and `adv` is ignored that cycle.
- `kld` asserted mid-sequence restarts at `START_IDX` immediately, regardless of current `rnd`.
- `rst` asserted mid-sequence returns the block to IDLE. A new `kld` is required to leave IDLE.

## Timing
- Load latency is 1 cycle. With `kld` sampled high at edge N, `out`=map(`START_IDX`) is visible after edge N.
- Step latency is 1 cycle per `adv` edge, with no bubbles. Full backward sweep from load: `START_IDX` `adv` cycles to reach `last`.
- `last` and `out` change on the same edge; no output lags another.
- Reset deassertion is synchronous to use: the first `kld` is honoured at the first rising edge after `rst` falls.
- No combinational path from inputs to outputs.

## Test plan
- **Reset:** assert `rst` mid-run with `rnd`=5.
  - Expect `out`=0, `rnd`=0, `valid`=0, `last`=0 immediately, without waiting for a clock edge.
  - 20 cycles of `adv`=1 afterwards must change nothing.
- **Full sweep, AES-128:** `kld` pulse, then `adv`=1 for 12 cycles.
  - `out[31:24]` must read 36, 1b, 80, 40, 20, 10, 08, 04, 02, 01, then 01, 01.
  - `last` rises on the 10th value and stays high.
  - `rnd` reads 9 down to 0, then holds at 0.
- **Stall:** during a sweep drive `adv`=1,0,0,1,0,1.
  - Values advance only on `adv` cycles: 36, 1b, 1b, 1b, 80, 80, 40.
- **Restart:** `kld` at `rnd`=4, and `kld`+`adv` together at `rnd`=2.
  - Both cases give next `out`=0x36000000, `rnd`=9, `last`=0.
- **Rapid reload:** 5 back-to-back `kld`/`adv` alternations.
  - `out` alternates 36, 1b, 36, 1b, … and `last` stays 0.
- **Parameter:** `START_IDX`=7 and `START_IDX`=0.
  - For 7: the first value is 0x80, and `last` is reached after 7 advances.
  - For 0: `out`=0x01000000 and `last`=1 immediately after `kld`.
